// File: rtl/ifft_pkg.sv
// Shared IFFT constants: default sample width, transform size, per-stage SDF feedback depths,
// and the compile-time clog2 helper used to size stage counters.
package ifft_pkg;

    localparam int IFFT_DATA_WIDTH   = 16;
    localparam int IFFT_SIZE         = 64;

    localparam int IFFT_STAGE0_DELAY = 32;
    localparam int IFFT_STAGE1_DELAY = 16;
    localparam int IFFT_STAGE2_DELAY = 8;
    localparam int IFFT_STAGE3_DELAY = 4;
    localparam int IFFT_STAGE4_DELAY = 2;
    localparam int IFFT_STAGE5_DELAY = 1;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/shift_registers_srl.sv
// Enable-gated delay line of CLOCK_CYCLES words; no reset so it maps onto shift-register primitives.
module shift_registers_srl #(
    parameter int CLOCK_CYCLES = 32,
    parameter int DATA_WIDTH   = 34
) (
    input  logic                  clk,
    input  logic                  i_ce,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_taps [CLOCK_CYCLES];

    always_ff @(posedge clk) begin
        if (i_ce) begin
            r_taps[0] <= i_data;
            for (int i = 1; i < CLOCK_CYCLES; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    assign o_data = r_taps[CLOCK_CYCLES-1];

endmodule

// File: rtl/ifft_r2sdf_stage.sv
// Radix-2 single-delay-feedback IFFT butterfly stage (no twiddle); define IFFT_STAGE_SCALE_EN
// to halve the output with round-half-up, otherwise the full DATA_WIDTH+1 result is output.
module ifft_r2sdf_stage
    import ifft_pkg::*;
#(
    parameter int DATA_WIDTH = IFFT_DATA_WIDTH,
    parameter int DELAY      = IFFT_STAGE0_DELAY,
`ifdef IFFT_STAGE_SCALE_EN
    localparam int OW        = DATA_WIDTH
`else
    localparam int OW        = DATA_WIDTH + 1
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clken,
    input  logic                         in_sync,
    input  logic signed [DATA_WIDTH-1:0] in_re,
    input  logic signed [DATA_WIDTH-1:0] in_im,
    output logic signed [OW-1:0]         out_re,
    output logic signed [OW-1:0]         out_im,
    output logic                         out_valid,
    output logic                         out_sync
);

    localparam int FW = DATA_WIDTH + 1;
    localparam int CW = clog2(2 * DELAY);

    function automatic logic signed [OW-1:0] fmt_out(input logic signed [FW-1:0] v);
`ifdef IFFT_STAGE_SCALE_EN
        logic signed [FW-1:0] r;
        r = v + FW'(1);
        return OW'(r >>> 1);
`else
        return v;
`endif
    endfunction

    logic [CW-1:0]           r_cnt;
    logic                    r_primed;
    logic signed [OW-1:0]    r_re_p1;
    logic signed [OW-1:0]    r_im_p1;
    logic                    r_vld_p1;
    logic                    r_sync_p1;

    logic [CW-1:0]           w_cnt;
    phase_e                  w_phase;
    logic signed [FW-1:0]    w_x_re, w_x_im;
    logic signed [FW-1:0]    w_fb_re, w_fb_im;
    logic signed [FW-1:0]    w_sum_re, w_sum_im;
    logic signed [FW-1:0]    w_dif_re, w_dif_im;
    logic signed [FW-1:0]    w_res_re, w_res_im;
    logic [2*FW-1:0]         w_line_in, w_line_out;
    logic                    w_vld_nxt;

    // A sync sample is always treated as phase 0, even mid-frame.
    assign w_cnt   = in_sync ? '0 : r_cnt;
    assign w_phase = w_cnt[CW-1] ? PH_B : PH_A;

    assign w_x_re  = {in_re[DATA_WIDTH-1], in_re};
    assign w_x_im  = {in_im[DATA_WIDTH-1], in_im};
    assign w_fb_re = w_line_out[2*FW-1:FW];
    assign w_fb_im = w_line_out[FW-1:0];

    assign w_sum_re = w_fb_re + w_x_re;
    assign w_sum_im = w_fb_im + w_x_im;
    assign w_dif_re = w_fb_re - w_x_re;
    assign w_dif_im = w_fb_im - w_x_im;

    assign w_line_in = (w_phase == PH_B) ? {w_dif_re, w_dif_im} : {w_x_re, w_x_im};
    assign w_res_re  = (w_phase == PH_B) ? w_sum_re : w_fb_re;
    assign w_res_im  = (w_phase == PH_B) ? w_sum_im : w_fb_im;

    // Valid only once a full half-frame since a sync has filled the line.
    assign w_vld_nxt = r_vld_p1 | ((w_phase == PH_B) & r_primed);

    shift_registers_srl #(
        .CLOCK_CYCLES (DELAY),
        .DATA_WIDTH   (2 * FW)
    ) u_fb_line (
        .clk    (clk),
        .i_ce   (clken & ~rst),
        .i_data (w_line_in),
        .o_data (w_line_out)
    );

    // p1: registered butterfly result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_re_p1   <= '0;
            r_im_p1   <= '0;
        end else if (clken) begin
            r_cnt     <= w_cnt + CW'(1);
            if (in_sync) r_primed <= 1'b1;
            r_vld_p1  <= w_vld_nxt;
            r_sync_p1 <= w_vld_nxt && (w_cnt == CW'(DELAY));
            if (w_vld_nxt) begin
                r_re_p1 <= fmt_out(w_res_re);
                r_im_p1 <= fmt_out(w_res_im);
            end
        end
    end

    assign out_re    = r_re_p1;
    assign out_im    = r_im_p1;
    assign out_valid = r_vld_p1;
    assign out_sync  = r_sync_p1;

endmodule

// File: tb/tb_ifft_r2sdf_stage.sv
// Scoreboard bench for ifft_r2sdf_stage (DELAY=32, DATA_WIDTH=16); expected outputs are queued per
// accepted sample and checked by an independent monitor. Expectations adapt to IFFT_STAGE_SCALE_EN.
module tb_ifft_r2sdf_stage;

    localparam int DW = 16;
    localparam int D  = 32;
`ifdef IFFT_STAGE_SCALE_EN
    localparam int OW = DW;
`else
    localparam int OW = DW + 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clken = 1'b0;
    logic                 in_sync = 1'b0;
    logic signed [DW-1:0] in_re = '0;
    logic signed [DW-1:0] in_im = '0;
    logic signed [OW-1:0] out_re, out_im;
    logic                 out_valid, out_sync;

    ifft_r2sdf_stage #(.DATA_WIDTH(DW), .DELAY(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .in_sync   (in_sync),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_valid (out_valid),
        .out_sync  (out_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk_v;
        bit v;
        bit s;
        bit chk_d;
        int re;
        int im;
    } exp_t;

    exp_t  q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    toggle  = 1'b0;
    string tname   = "init";

    function automatic int sc(input int v);
`ifdef IFFT_STAGE_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    task automatic samp(input bit sync, input int re, input int im,
                        input bit v, input bit s, input int ere, input int eim);
        @(negedge clk);
        rst = 1'b0; clken = 1'b1; in_sync = sync;
        in_re = DW'(re); in_im = DW'(im);
        q.push_back('{1'b1, v, s, 1'b1, ere, eim});
        if (toggle) begin
            @(negedge clk);
            clken = 1'b0; in_sync = 1'b1;
            in_re = DW'($urandom); in_im = DW'($urandom);
        end
    endtask

    task automatic do_reset(input bit en);
        @(negedge clk);
        rst = 1'b1; clken = en; in_sync = 1'b1; in_re = DW'(12345); in_im = DW'(-777);
        @(negedge clk);
        rst = 1'b0; clken = 1'b0; in_sync = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_sync !== 1'b0 || out_re !== '0 || out_im !== '0) begin
            n_fail++;
            $display("FAIL %s reset_state: got v=%b s=%b %0d/%0d want 0 0 0/0",
                     tname, out_valid, out_sync, out_re, out_im);
        end
    endtask

    // Impulse amp at sample 0 after fresh priming, followed by one all-zero frame.
    task automatic impulse_frames(input int amp);
        for (int c = 0; c < 2*D; c++) begin
            if (c < D)       samp(c == 0, (c == 0) ? amp : 0, 0, 1'b0, 1'b0, 0, 0);
            else if (c == D) samp(1'b0, 0, 0, 1'b1, 1'b1, amp, 0);
            else             samp(1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
        end
        for (int c = 0; c < 2*D; c++)
            samp(c == 0, 0, 0, 1'b1, c == D, (c == 0) ? amp : 0, 0);
    endtask

    // Monitor: pops one expectation per accepted sample; checks holds on stalled cycles.
    initial begin
        exp_t e;
        bit adv, hr, have_prev;
        logic signed [OW-1:0] er, ei, p_re, p_im;
        logic p_v, p_s;
        have_prev = 1'b0;
        p_re = '0; p_im = '0; p_v = 1'b0; p_s = 1'b0;
        forever begin
            @(posedge clk);
            adv = clken && !rst;
            hr  = rst;
            #1;
            if (adv) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL %s unexpected_sample: queue empty", tname);
                end else begin
                    e = q.pop_front();
                    if (e.chk_v) begin
                        n_tests++;
                        if (out_valid !== e.v || out_sync !== e.s) begin
                            n_fail++;
                            $display("FAIL %s vld_sync: got v=%b s=%b want v=%b s=%b",
                                     tname, out_valid, out_sync, e.v, e.s);
                        end
                    end
                    if (e.chk_d) begin
                        er = OW'(sc(e.re));
                        ei = OW'(sc(e.im));
                        n_tests++;
                        if (out_re !== er || out_im !== ei) begin
                            n_fail++;
                            $display("FAIL %s data: got %0d/%0d want %0d/%0d",
                                     tname, out_re, out_im, er, ei);
                        end
                    end
                end
            end else if (!hr && have_prev) begin
                n_tests++;
                if (out_re !== p_re || out_im !== p_im || out_valid !== p_v || out_sync !== p_s) begin
                    n_fail++;
                    $display("FAIL %s hold: got %0d/%0d v=%b s=%b want %0d/%0d v=%b s=%b",
                             tname, out_re, out_im, out_valid, out_sync, p_re, p_im, p_v, p_s);
                end
            end
            p_re = out_re; p_im = out_im; p_v = out_valid; p_s = out_sync;
            have_prev = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tname = "reset";
        repeat (2) @(negedge clk);
        do_reset(1'b1);

        tname = "impulse";
        impulse_frames(1000);

        tname = "constant";
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 2*D; c++)
                samp(c == 0, 100, 50, 1'b1, c == D, (c >= D) ? 200 : 0, (c >= D) ? 100 : 0);

        tname = "overflow";
        for (int c = 0; c < 2*D; c++)
            samp(c == 0, (c < D) ? 32767 : -32768, 0, 1'b1, c == D, (c < D) ? 0 : -1, 0);
        for (int c = 0; c < 2*D; c++)
            samp(c == 0, 0, 0, 1'b1, c == D, (c < D) ? 65535 : 0, 0);

        tname = "clken_toggle";
        do_reset(1'b1);
        toggle = 1'b1;
        impulse_frames(1000);
        toggle = 1'b0;

        tname = "reset_midframe";
        for (int c = 0; c < 40; c++)
            samp(c == 0, 300, -200, 1'b1, c == D, (c >= D) ? 600 : 0, (c >= D) ? -400 : 0);
        do_reset(1'b0);
        for (int c = 0; c < 40; c++)
            samp(1'b0, 77, 77, 1'b0, 1'b0, 0, 0);
        for (int c = 0; c < 10; c++)
            samp(c == 0, 77, -77, 1'b0, 1'b0, 0, 0);
        impulse_frames(500);

        tname = "resync";
        for (int c = 0; c < 10; c++)
            samp(c == 0, 0, 0, 1'b1, 1'b0, 0, 0);
        samp(1'b1, 400, 0, 1'b1, 1'b0, 0, 0);
        for (int c = 1; c < 2*D; c++)
            samp(1'b0, 0, 0, 1'b1, c == D, (c == D) ? 400 : 0, 0);
        for (int c = 0; c < 4; c++)
            samp(c == 0, 0, 0, 1'b1, 1'b0, (c == 0) ? 400 : 0, 0);

        @(negedge clk);
        clken = 1'b0; in_sync = 1'b0;
        repeat (3) @(negedge clk);
        tname = "drain";
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s queue: got %0d entries left want 0", tname, q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
